// File: rtl/sort_pkg.sv
// Shared constants for the sort pipeline (frame loader and bubble sorter).
package sort_pkg;

  localparam int unsigned SORT_N = 100;
  localparam int unsigned SORT_W = 32;

  typedef logic [SORT_W-1:0] word_t;

endpackage

// File: rtl/sort_frame_loader.sv
// Collects a valid/ready word stream into one N-entry frame, pads unfilled
// slots with PAD_VALUE, and holds the frame until the consumer accepts it.
module sort_frame_loader
  import sort_pkg::*;
#(
  parameter int unsigned    N         = SORT_N,
  parameter int unsigned    W         = SORT_W,
  parameter logic [W-1:0]   PAD_VALUE = {W{1'b1}},
  parameter int unsigned    CW        = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          frame_valid,
  input  logic          frame_ready,
  output logic [W-1:0]  frame_data [0:N-1],
  output logic [CW-1:0] frame_count
);

  typedef enum logic {Fill, Hold} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] frame_count_q, frame_count_d;
  logic          wr_en;
  logic [W-1:0]  mem_q [0:N-1];

  // Next-state, handshake outputs and buffer write enable.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    frame_count_d = frame_count_q;
    in_ready      = 1'b0;
    frame_valid   = 1'b0;
    wr_en         = 1'b0;
    unique case (state_q)
      Fill: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en         = 1'b1;
          wr_ptr_d      = wr_ptr_q + 1'b1;
          frame_count_d = wr_ptr_q + 1'b1;
          // The Nth word closes the frame even without in_last.
          if (in_last || (wr_ptr_q == CW'(N - 1))) begin
            state_d  = Hold;
            wr_ptr_d = '0;
          end
        end
      end
      Hold: begin
        frame_valid = 1'b1;
        if (frame_ready) begin
          state_d       = Fill;
          frame_count_d = '0;
        end
      end
    endcase
  end

  // Control state: FSM, write pointer and real-word count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= Fill;
      wr_ptr_q      <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Frame buffer; left unreset since the count-based pad mask hides stale slots.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Slots at or beyond the real-word count always read as padding.
  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      frame_data[k] = (CW'(k) < frame_count_q) ? mem_q[k] : PAD_VALUE;
    end
  end

  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_sort_frame_loader.sv
// Directed self-checking bench for sort_frame_loader (N=100, W=32).
module tb_sort_frame_loader;

  localparam int unsigned N   = 100;
  localparam logic [31:0] PAD = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        frame_valid;
  logic        frame_ready;
  logic [31:0] frame_data [0:N-1];
  logic [6:0]  frame_count;

  int checks = 0;
  int errors = 0;

  sort_frame_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one word at a negedge and return at the negedge after its handshake.
  task automatic send(input logic [31:0] d, input logic l);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (in_ready !== 1'b1) begin
      @(negedge clk);
      waited++;
      if (waited > 50) begin
        check("send_timeout", 32'(in_ready), 32'd1);
        return;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_frame();
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  task automatic check_pads(input string tag, input int unsigned from);
    for (int unsigned k = from; k < N; k++) check(tag, frame_data[k], PAD);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    frame_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_in_ready",    32'(in_ready),    32'd1);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_slot0",       frame_data[0],    PAD);
    check("rst_slot99",      frame_data[99],   PAD);
    rst_n = 1'b1;
    @(negedge clk);

    // 1) Full frame 99..0, in_last on the last word
    for (int unsigned i = 0; i < N; i++) begin
      if (i == N - 1) check("full_valid_before_last", 32'(frame_valid), 32'd0);
      send(32'(N - 1 - i), i == N - 1);
    end
    idle();
    check("full_valid",    32'(frame_valid), 32'd1);
    check("full_in_ready", 32'(in_ready),    32'd0);
    check("full_count",    32'(frame_count), 32'd100);
    check("full_slot0",    frame_data[0],    32'd99);
    check("full_slot99",   frame_data[99],   32'd0);
    for (int unsigned k = 0; k < N; k++) check("full_slot", frame_data[k], 32'(N - 1 - k));
    release_frame();
    check("full_released_valid", 32'(frame_valid), 32'd0);
    check("full_released_count", 32'(frame_count), 32'd0);
    check("full_released_slot0", frame_data[0],    PAD);

    // 2) Short frame {5,1,7}
    send(32'd5, 1'b0);
    send(32'd1, 1'b0);
    send(32'd7, 1'b1);
    idle();
    check("short_valid", 32'(frame_valid), 32'd1);
    check("short_count", 32'(frame_count), 32'd3);
    check("short_slot0", frame_data[0], 32'd5);
    check("short_slot1", frame_data[1], 32'd1);
    check("short_slot2", frame_data[2], 32'd7);
    check_pads("short_pad", 3);
    release_frame();

    // 3+4) Auto-close without in_last, then a 101st word held off for 20 cycles
    for (int unsigned i = 0; i < N; i++) send(32'(1000 + i), 1'b0);
    check("auto_valid",    32'(frame_valid), 32'd1);
    check("auto_in_ready", 32'(in_ready),    32'd0);
    check("auto_count",    32'(frame_count), 32'd100);
    in_valid = 1'b1;
    in_data  = 32'd2024;
    in_last  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready),    32'd0);
      check("bp_valid",    32'(frame_valid), 32'd1);
      check("bp_count",    32'(frame_count), 32'd100);
      check("bp_slot0",    frame_data[0],    32'd1000);
      check("bp_slot99",   frame_data[99],   32'd1099);
    end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    // Bubble cycle: frame released, waiting word not yet taken
    check("bubble_valid",    32'(frame_valid), 32'd0);
    check("bubble_in_ready", 32'(in_ready),    32'd1);
    check("bubble_count",    32'(frame_count), 32'd0);
    @(negedge clk);
    idle();
    check("next_valid", 32'(frame_valid), 32'd1);
    check("next_count", 32'(frame_count), 32'd1);
    check("next_slot0", frame_data[0],    32'd2024);
    check("next_slot1", frame_data[1],    PAD);
    release_frame();

    // 5) Back-to-back: A = 4 words, B = 2 words
    for (int unsigned i = 0; i < 4; i++) send(32'(10 + i), i == 3);
    idle();
    check("a_count", 32'(frame_count), 32'd4);
    check("a_slot3", frame_data[3],    32'd13);
    release_frame();
    send(32'd20, 1'b0);
    send(32'd21, 1'b1);
    idle();
    check("b_count", 32'(frame_count), 32'd2);
    check("b_slot0", frame_data[0],    32'd20);
    check("b_slot1", frame_data[1],    32'd21);
    check_pads("b_pad", 2);
    release_frame();

    // 6) Reset after 50 words in FILL
    for (int unsigned i = 0; i < 50; i++) send(32'(500 + i), 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",    32'(frame_valid), 32'd0);
    check("mid_rst_count",    32'(frame_count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready),    32'd1);
    check_pads("mid_rst_pad", 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'd7, 1'b0);
    send(32'd8, 1'b1);
    idle();
    check("post_rst_valid", 32'(frame_valid), 32'd1);
    check("post_rst_count", 32'(frame_count), 32'd2);
    check("post_rst_slot0", frame_data[0],    32'd7);
    check("post_rst_slot1", frame_data[1],    32'd8);
    check("post_rst_slot2", frame_data[2],    PAD);
    release_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
